// File: rtl/sram_fifo_ctrl.sv
// sram_fifo_ctrl
// FIFO sequencer in front of a dual-port SRAM macro (port A write-only,
// port B read-only). Incoming valid/ready writes become port-A write cycles.
// Port B prefetches into a 2-entry output buffer that drives a valid/ready
// read stream. After reset the macro is woken (RETN) for WAKE_CYC cycles
// before any access is made.
//
// Ports
//   clk, rst                  clock (also the macro clock), sync active-high reset
//   flush                     synchronous clear of all contents (RUN only)
//   wr_valid/wr_ready/wr_data producer stream
//   rd_valid/rd_ready/rd_data consumer stream, rd_data is a register
//   count                     SRAM words + in-flight read + buffered words
//   sram_retn                 macro retention control
//   sram_cena/wena/aa/da      macro port A (active-low enables)
//   sram_cenb/ab, sram_qb     macro port B (qb valid the cycle after access)
module sram_fifo_ctrl #(
    parameter int ADDR_W   = 11,
    parameter int DATA_W   = 32,
    parameter int WAKE_CYC = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W+1:0] count,
    output logic              sram_retn,
    output logic              sram_cena,
    output logic              sram_wena,
    output logic [ADDR_W-1:0] sram_aa,
    output logic [DATA_W-1:0] sram_da,
    output logic              sram_cenb,
    output logic [ADDR_W-1:0] sram_ab,
    input  logic [DATA_W-1:0] sram_qb
);

    localparam int CNT_W = ADDR_W + 2;
    localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [7:0] WAKE_LAST = 8'(WAKE_CYC - 1);

    localparam logic [1:0] ST_RET  = 2'd0;
    localparam logic [1:0] ST_WAKE = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    logic [1:0]        state_reg;
    logic [7:0]        wake_cnt_reg;
    logic [ADDR_W-1:0] wptr_reg;
    logic [ADDR_W-1:0] rptr_reg;
    logic [ADDR_W:0]   sram_cnt_reg;
    logic              inflight_reg;
    logic [DATA_W-1:0] buf_reg [2];
    logic [1:0]        buf_cnt_reg;
    logic [ADDR_W-1:0] aa_hold_reg;
    logic [DATA_W-1:0] da_hold_reg;
    logic [ADDR_W-1:0] ab_hold_reg;

    logic       active;
    logic       wr_fire;
    logic       pop;
    logic       issue;
    logic [2:0] slots_used;

    // Accesses only happen in RUN, and never in a reset or flush cycle.
    assign active   = (state_reg == ST_RUN) && !rst && !flush;
    assign wr_ready = active && (sram_cnt_reg < DEPTH_C);
    assign wr_fire  = wr_valid && wr_ready;

    assign rd_valid = (buf_cnt_reg != 2'd0);
    assign rd_data  = buf_reg[0];
    assign pop      = rd_valid && rd_ready;

    // A read may be issued if the buffer still has room for it once the
    // word already in flight lands, crediting a pop in this same cycle.
    assign slots_used = 3'(buf_cnt_reg) + 3'(inflight_reg);
    assign issue      = active && (sram_cnt_reg != '0) && (slots_used < (3'd2 + 3'(pop)));

    assign count = CNT_W'(sram_cnt_reg) + CNT_W'(inflight_reg) + CNT_W'(buf_cnt_reg);

    assign sram_retn = (state_reg != ST_RET);
    assign sram_cena = !wr_fire;
    assign sram_wena = !wr_fire;
    assign sram_aa   = wr_fire ? wptr_reg : aa_hold_reg;
    assign sram_da   = wr_fire ? wr_data  : da_hold_reg;
    assign sram_cenb = !issue;
    assign sram_ab   = issue ? rptr_reg : ab_hold_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_RET;
            wake_cnt_reg <= '0;
            wptr_reg     <= '0;
            rptr_reg     <= '0;
            sram_cnt_reg <= '0;
            inflight_reg <= 1'b0;
            buf_cnt_reg  <= '0;
            aa_hold_reg  <= '0;
            da_hold_reg  <= '0;
            ab_hold_reg  <= '0;
            for (int i = 0; i < 2; i++) begin
                buf_reg[i] <= '0;
            end
        end else begin
            case (state_reg)
                ST_RET: begin
                    state_reg    <= ST_WAKE;
                    wake_cnt_reg <= '0;
                end
                ST_WAKE: begin
                    if (wake_cnt_reg == WAKE_LAST) begin
                        state_reg <= ST_RUN;
                    end else begin
                        wake_cnt_reg <= wake_cnt_reg + 8'd1;
                    end
                end
                ST_RUN:  state_reg <= ST_RUN;
                default: state_reg <= ST_RET;
            endcase

            if (wr_fire) begin
                wptr_reg    <= wptr_reg + 1'b1;
                aa_hold_reg <= wptr_reg;
                da_hold_reg <= wr_data;
            end

            if (issue) begin
                rptr_reg    <= rptr_reg + 1'b1;
                ab_hold_reg <= rptr_reg;
            end

            inflight_reg <= issue;

            case ({wr_fire, issue})
                2'b10:   sram_cnt_reg <= sram_cnt_reg + 1'b1;
                2'b01:   sram_cnt_reg <= sram_cnt_reg - 1'b1;
                default: sram_cnt_reg <= sram_cnt_reg;
            endcase

            // The issue rule guarantees a push never meets a full buffer.
            case ({inflight_reg, pop})
                2'b11: begin
                    if (buf_cnt_reg == 2'd2) begin
                        buf_reg[0] <= buf_reg[1];
                        buf_reg[1] <= sram_qb;
                    end else begin
                        buf_reg[0] <= sram_qb;
                    end
                end
                2'b10: begin
                    if (buf_cnt_reg == 2'd0) begin
                        buf_reg[0] <= sram_qb;
                    end else begin
                        buf_reg[1] <= sram_qb;
                    end
                    buf_cnt_reg <= buf_cnt_reg + 2'd1;
                end
                2'b01: begin
                    buf_reg[0]  <= buf_reg[1];
                    buf_cnt_reg <= buf_cnt_reg - 2'd1;
                end
                default: buf_cnt_reg <= buf_cnt_reg;
            endcase

            // Flush overrides the updates above; the word arriving on qb
            // this cycle is dropped with everything else.
            if ((state_reg == ST_RUN) && flush) begin
                wptr_reg     <= '0;
                rptr_reg     <= '0;
                sram_cnt_reg <= '0;
                inflight_reg <= 1'b0;
                buf_cnt_reg  <= '0;
                for (int i = 0; i < 2; i++) begin
                    buf_reg[i] <= '0;
                end
            end
        end
    end

endmodule
